// File: rtl/serdes_rr_arbiter_pkg.sv
// Shared types and constants for the serdes round-robin arbiter.
package serdes_rr_arbiter_pkg;

    localparam int WORD_W = 64;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } arb_state_e;

    // Transfer direction latched at grant; both bits set means swap.
    typedef struct packed {
        logic is_des;
        logic is_ser;
    } xfer_mode_t;

endpackage

// File: rtl/serdes_rr_arbiter_rr_pick.sv
// Combinational cyclic priority picker: first pending requester at or after ptr wins.
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pend_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    int j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // ptr is always below NUM_REQ, so a single wrap suffices
            j = int'(ptr_i) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!any_o && pend_i[j]) begin
                any_o    = 1'b1;
                idx_o    = IDX_W'(j);
                gnt_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/serdes_rr_arbiter.sv
// Round-robin arbiter sharing one N-word serdes between NUM_REQ requesters.
module serdes_rr_arbiter
    import serdes_rr_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 3,
    parameter  int N       = 4,
    localparam int IDX_W   = $clog2(NUM_REQ),
    localparam int CNT_W   = (N > 1) ? $clog2(N) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_startDes_i,
    input  logic [NUM_REQ-1:0]        req_startSer_i,
    output logic [NUM_REQ-1:0]        req_canReceive_o,
    input  logic [NUM_REQ*WORD_W-1:0] req_des_i,
    input  logic [NUM_REQ-1:0]        req_des_isReady_i,
    output logic [NUM_REQ-1:0]        req_des_canReceive_o,
    output logic [WORD_W-1:0]         req_ser_o,
    output logic [NUM_REQ-1:0]        req_ser_isReady_o,
    input  logic [NUM_REQ-1:0]        req_ser_canReceive_i,
    output logic                      req_isLast_o,
    output logic                      cmd_startDes_o,
    output logic                      cmd_startSer_o,
    input  logic                      cmd_canReceive_i,
    output logic [WORD_W-1:0]         sd_des_o,
    output logic                      sd_des_isReady_o,
    input  logic                      sd_des_canReceive_i,
    input  logic [WORD_W-1:0]         sd_ser_i,
    input  logic                      sd_ser_isReady_i,
    output logic                      sd_ser_canReceive_o,
    output logic                      busy_o,
    output logic [IDX_W-1:0]          owner_o
);

    arb_state_e         state_q;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q;
    xfer_mode_t         mode_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [NUM_REQ-1:0] pend, pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               grant, active, beat, last;
    logic [IDX_W-1:0]   eff_owner;
    xfer_mode_t         eff_mode;

    assign pend = req_startDes_i | req_startSer_i;

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .pend_i (pend),
        .ptr_i  (ptr_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    // Gating with rst_ni keeps every output quiet while reset is held.
    assign active = (state_q == ST_ACTIVE);
    assign grant  = rst_ni & !active & pick_any & cmd_canReceive_i;

    always_comb begin
        eff_owner = grant ? pick_idx : owner_q;
        eff_mode  = '0;
        if (grant) begin
            eff_mode.is_des = req_startDes_i[pick_idx];
            eff_mode.is_ser = req_startSer_i[pick_idx];
        end else if (active) begin
            eff_mode = mode_q;
        end
    end

    assign ptr_d = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

    // Routing is live in the grant cycle so the serdes can take beat 1 immediately.
    always_comb begin
        req_des_canReceive_o = '0;
        req_ser_isReady_o    = '0;
        sd_des_o             = req_des_i[eff_owner*WORD_W +: WORD_W];
        sd_des_isReady_o     = eff_mode.is_des & req_des_isReady_i[eff_owner];
        sd_ser_canReceive_o  = eff_mode.is_ser & req_ser_canReceive_i[eff_owner];
        req_des_canReceive_o[eff_owner] = eff_mode.is_des & sd_des_canReceive_i;
        req_ser_isReady_o[eff_owner]    = eff_mode.is_ser & sd_ser_isReady_i;
    end

    assign req_ser_o        = sd_ser_i;
    assign req_canReceive_o = grant ? pick_gnt : '0;
    assign cmd_startDes_o   = grant & eff_mode.is_des;
    assign cmd_startSer_o   = grant & eff_mode.is_ser;
    assign busy_o           = grant | active;
    assign owner_o          = eff_owner;

    // Swap transfers are paced by the des side.
    assign beat = eff_mode.is_des ? (sd_des_isReady_o & sd_des_canReceive_i)
                                  : (sd_ser_isReady_i & sd_ser_canReceive_o);
    assign last = beat & (cnt_q == CNT_W'(N - 1));
    assign req_isLast_o = last;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            mode_q  <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant) begin
                        owner_q <= pick_idx;
                        mode_q  <= eff_mode;
                        ptr_q   <= ptr_d;
                        if (last) begin
                            cnt_q <= '0;
                        end else begin
                            cnt_q   <= cnt_q + CNT_W'(beat);
                            state_q <= ST_ACTIVE;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (last) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (beat) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serdes_rr_arbiter.sv
// Directed bench for serdes_rr_arbiter: N=4 main instance plus an N=1 instance.
module tb_serdes_rr_arbiter;

    localparam int NR = 3;
    localparam int IW = $clog2(NR);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     startDes, startSer, desRdy, serCan;
    logic [NR*64-1:0]  reqDes;
    logic              cmdCan, sdDesCan, sdSerRdy;
    logic [63:0]       sdSer;

    logic [NR-1:0]     canRx, desCan, serRdy;
    logic [63:0]       reqSer, sdDes;
    logic              isLast, cDes, cSer, sdDesRdy, sdSerCan, busy;
    logic [IW-1:0]     owner;

    logic [NR-1:0]     u1_canRx, u1_desCan, u1_serRdy;
    logic [63:0]       u1_reqSer, u1_sdDes;
    logic              u1_isLast, u1_cDes, u1_cSer, u1_sdDesRdy, u1_sdSerCan, u1_busy;
    logic [IW-1:0]     u1_owner;

    int n_chk = 0;
    int n_err = 0;
    logic [63:0] w [4];
    int order [4];

    always #5 clk = ~clk;

    serdes_rr_arbiter #(.NUM_REQ(NR), .N(4)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_startDes_i(startDes), .req_startSer_i(startSer), .req_canReceive_o(canRx),
        .req_des_i(reqDes), .req_des_isReady_i(desRdy), .req_des_canReceive_o(desCan),
        .req_ser_o(reqSer), .req_ser_isReady_o(serRdy), .req_ser_canReceive_i(serCan),
        .req_isLast_o(isLast), .cmd_startDes_o(cDes), .cmd_startSer_o(cSer),
        .cmd_canReceive_i(cmdCan), .sd_des_o(sdDes), .sd_des_isReady_o(sdDesRdy),
        .sd_des_canReceive_i(sdDesCan), .sd_ser_i(sdSer), .sd_ser_isReady_i(sdSerRdy),
        .sd_ser_canReceive_o(sdSerCan), .busy_o(busy), .owner_o(owner)
    );

    serdes_rr_arbiter #(.NUM_REQ(NR), .N(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_startDes_i(startDes), .req_startSer_i(startSer), .req_canReceive_o(u1_canRx),
        .req_des_i(reqDes), .req_des_isReady_i(desRdy), .req_des_canReceive_o(u1_desCan),
        .req_ser_o(u1_reqSer), .req_ser_isReady_o(u1_serRdy), .req_ser_canReceive_i(serCan),
        .req_isLast_o(u1_isLast), .cmd_startDes_o(u1_cDes), .cmd_startSer_o(u1_cSer),
        .cmd_canReceive_i(cmdCan), .sd_des_o(u1_sdDes), .sd_des_isReady_o(u1_sdDesRdy),
        .sd_des_canReceive_i(sdDesCan), .sd_ser_i(sdSer), .sd_ser_isReady_i(sdSerRdy),
        .sd_ser_canReceive_o(u1_sdSerCan), .busy_o(u1_busy), .owner_o(u1_owner)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_in();
        startDes = '0; startSer = '0; desRdy = '0; serCan = '0; reqDes = '0;
        cmdCan = 1'b0; sdDesCan = 1'b0; sdSerRdy = 1'b0; sdSer = '0;
    endtask

    // Leaves the bench at posedge+1 with reset released and inputs idle.
    task automatic do_reset();
        rst_n = 1'b0;
        clr_in();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        w[0] = 64'hAAAA_0000_0000_000A;
        w[1] = 64'hBBBB_0000_0000_000B;
        w[2] = 64'hCCCC_0000_0000_000C;
        w[3] = 64'hDDDD_0000_0000_000D;
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 0;

        // 1: reset state
        do_reset();
        #1;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_owner", 64'(owner), 0);
        chk("rst_canRx", 64'(canRx), 0);
        chk("rst_cmd", 64'({cDes, cSer}), 0);
        chk("rst_route", 64'({sdDesRdy, sdSerCan, isLast, desCan, serRdy}), 0);
        chk("rst_u1_busy", 64'(u1_busy), 0);

        // 2: requester 1 loads A..D
        nxt();
        startDes = 3'b010; cmdCan = 1'b1; desRdy = 3'b010; sdDesCan = 1'b1;
        reqDes[64 +: 64] = w[0];
        #1;
        chk("t2_canRx", 64'(canRx), 64'(3'b010));
        chk("t2_cmd", 64'({cDes, cSer}), 64'(2'b10));
        chk("t2_owner", 64'(owner), 1);
        chk("t2_desCan0", 64'(desCan), 64'(3'b010));
        chk("t2_sdDes0", sdDes, w[0]);
        chk("t2_last0", 64'(isLast), 0);
        for (int b = 1; b < 4; b++) begin
            nxt();
            startDes = '0;
            reqDes[64 +: 64] = w[b];
            #1;
            chk("t2_canRx_act", 64'(canRx), 0);
            chk("t2_sdDes", sdDes, w[b]);
            chk("t2_busy", 64'(busy), 1);
            chk("t2_last", 64'(isLast), 64'(b == 3));
        end
        nxt();
        desRdy = '0;
        #1;
        chk("t2_busy_fall", 64'(busy), 0);

        // 3: all pending from reset, grant order 0,1,2,0
        do_reset();
        startSer = 3'b111; cmdCan = 1'b1; sdSerRdy = 1'b1; serCan = 3'b111;
        for (int it = 0; it < 4; it++) begin
            for (int b = 0; b < 4; b++) begin
                sdSer = 64'h5000 + 64'(it * 16 + b);
                #1;
                if (b == 0) begin
                    chk("t3_grant", 64'(canRx), 64'(3'b001 << order[it]));
                    chk("t3_cmdSer", 64'(cSer), 1);
                end else begin
                    chk("t3_nogrant", 64'(canRx), 0);
                end
                chk("t3_owner", 64'(owner), 64'(order[it]));
                chk("t3_serRdy", 64'(serRdy), 64'(3'b001 << order[it]));
                chk("t3_reqSer", reqSer, 64'h5000 + 64'(it * 16 + b));
                chk("t3_last", 64'(isLast), 64'(b == 3));
                nxt();
                if (b == 0 && it != 0) startSer[order[it]] = 1'b0;
            end
        end
        #1;
        chk("t3_idle", 64'(busy), 0);

        // 4: swap by requester 2 with ser back-pressure
        do_reset();
        startDes = 3'b100; startSer = 3'b100; cmdCan = 1'b1; desRdy = 3'b100;
        sdSerRdy = 1'b1; sdDesCan = 1'b0; serCan = '0;
        reqDes[128 +: 64] = w[0];
        for (int s = 0; s < 5; s++) begin
            #1;
            if (s == 0) begin
                chk("t4_grant", 64'(canRx), 64'(3'b100));
                chk("t4_cmd", 64'({cDes, cSer}), 64'(2'b11));
            end
            chk("t4_stall_last", 64'(isLast), 0);
            chk("t4_stall_hs", 64'({sdSerCan, desCan}), 0);
            chk("t4_stall_busy", 64'(busy), 1);
            nxt();
            if (s == 0) begin
                startDes = '0; startSer = '0;
            end
        end
        sdDesCan = 1'b1; serCan = 3'b100;
        for (int b = 0; b < 4; b++) begin
            reqDes[128 +: 64] = w[b];
            sdSer = ~w[b];
            #1;
            chk("t4_sdDes", sdDes, w[b]);
            chk("t4_desCan", 64'(desCan), 64'(3'b100));
            chk("t4_serRdy", 64'(serRdy), 64'(3'b100));
            chk("t4_sdSerCan", 64'(sdSerCan), 1);
            chk("t4_last", 64'(isLast), 64'(b == 3));
            nxt();
        end
        #1;
        chk("t4_idle", 64'(busy), 0);

        // 5: reset at beat 2 of requester 1's transfer
        do_reset();
        startDes = 3'b010; cmdCan = 1'b1; desRdy = 3'b111; sdDesCan = 1'b1;
        nxt();
        startDes = '0;
        nxt();
        startDes = 3'b101;
        #1;
        chk("t5_pre_owner", 64'(owner), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", 64'(busy), 0);
        chk("t5_rst_route", 64'({sdDesRdy, desCan, canRx, cDes}), 0);
        chk("t5_rst_owner", 64'(owner), 0);
        nxt();
        rst_n = 1'b1;
        #1;
        chk("t5_regrant", 64'(canRx), 64'(3'b001));
        chk("t5_owner", 64'(owner), 0);

        // 6: N=1, grant and last together
        do_reset();
        startDes = 3'b001; desRdy = 3'b001; cmdCan = 1'b1; sdDesCan = 1'b1;
        #1;
        chk("t6_grant", 64'(u1_canRx), 64'(3'b001));
        chk("t6_last", 64'(u1_isLast), 1);
        chk("t6_busy", 64'(u1_busy), 1);
        nxt();
        startDes = '0;
        #1;
        chk("t6_idle_busy", 64'(u1_busy), 0);
        chk("t6_idle_last", 64'({u1_isLast, u1_sdDesRdy}), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
